// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - 2-master/1-slave whole-transaction arbiter for the shared data SRAM
// Optional feature: MEM_ARBITER_RR_EN selects round-robin m0/m1 arbitration (default: fixed priority)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // m0: IFU, read only
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // m1: LSU, read and write
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [STRB_WIDTH-1:0] m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // slave: SRAM
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  typedef enum logic [1:0] {IDLE, RD_M0, RD_M1, WR_M1} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   m1_wr_req;
  logic   m1_req;
  logic   m0_wins;

  // Either write channel valid counts as a write request; write beats read inside m1
  assign m1_wr_req = m1_awvalid | m1_wvalid;
  assign m1_req    = m1_wr_req | m1_arvalid;

`ifdef MEM_ARBITER_RR_EN
  // 1 = m1 was granted last, so m0 wins the next contention
  logic last_grant;
  assign m0_wins = m0_arvalid & (~m1_req | last_grant);
`else
  assign m0_wins = m0_arvalid & ~m1_req;
`endif

  // Grant FSM: decision in IDLE, route becomes active on the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (m0_wins) begin
            state <= RD_M0;
`ifdef MEM_ARBITER_RR_EN
            last_grant <= 1'b0;
`endif
          end else if (m1_wr_req) begin
            state <= WR_M1;
`ifdef MEM_ARBITER_RR_EN
            last_grant <= 1'b1;
`endif
          end else if (m1_arvalid) begin
            state <= RD_M1;
`ifdef MEM_ARBITER_RR_EN
            last_grant <= 1'b1;
`endif
          end
        end
        RD_M0, RD_M1: begin
          if (s_rvalid && s_rready) state <= IDLE;
        end
        WR_M1: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted master to the SRAM; everything not granted is held at 0
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (state)
      RD_M0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      RD_M1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      WR_M1: begin
        // Each channel is closed off once its beat has been accepted
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done;
        m1_awready = s_awready & ~aw_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done;
        m1_wready  = s_wready & ~w_done;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
  logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
  logic        m1_awvalid, m1_wvalid, m1_bready;
  logic [3:0]  m1_wstrb;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
  logic        m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  int          checks = 0;
  int          failures = 0;
  int          aw_fires;
  int          w_fires;
  logic [31:0] mem_word;
  logic [175:0] all_out;

  assign all_out = {m0_arready, m0_rdata, m0_rvalid, m1_arready, m1_rdata, m1_rvalid,
                    m1_awready, m1_wready, m1_bvalid, s_araddr, s_awaddr, s_wdata, s_wstrb,
                    s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready};

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = 0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = 0; m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = 0; m1_awvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wvalid = 0; m1_bready = 0;
    s_arready = 0; s_rdata = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Entered at the settle point of the first cycle in RD_m; leaves at the settle point of the IDLE cycle
  task automatic serve_read(input int m, input logic [31:0] addr, input logic [31:0] data);
    check("rd_s_arvalid", {31'b0, s_arvalid}, 1);
    check("rd_s_araddr", s_araddr, addr);
    check("rd_arready_granted", {31'b0, (m == 0) ? m0_arready : m1_arready}, 1);
    check("rd_arready_other", {31'b0, (m == 0) ? m1_arready : m0_arready}, 0);
    tick();
    if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = data; m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    check("rd_rvalid_granted", {31'b0, (m == 0) ? m0_rvalid : m1_rvalid}, 1);
    check("rd_rdata_granted", (m == 0) ? m0_rdata : m1_rdata, data);
    check("rd_rvalid_other", {31'b0, (m == 0) ? m1_rvalid : m0_rvalid}, 0);
    check("rd_rdata_other", (m == 0) ? m1_rdata : m0_rdata, 0);
    check("rd_s_rready", {31'b0, s_rready}, 1);
    tick();
    s_rvalid = 1'b0; s_rdata = 0;
    #1;
    check("rd_idle_s_arvalid", {31'b0, s_arvalid}, 0);
    check("rd_idle_rvalid", {31'b0, (m == 0) ? m0_rvalid : m1_rvalid}, 0);
  endtask

  task automatic sample_write();
    if (s_awvalid && s_awready) aw_fires++;
    if (s_wvalid && s_wready) begin
      w_fires++;
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) mem_word[8*b +: 8] = s_wdata[8*b +: 8];
    end
  endtask

  initial begin
    do_reset();
    check("reset_all_out_zero", {31'b0, |all_out}, 0);

    // 1: single m0 read
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; s_arready = 1'b1;
    #1;
    check("t1_idle_s_arvalid", {31'b0, s_arvalid}, 0);
    tick();
    serve_read(0, 32'h8000_0000, 32'hDEAD_BEEF);
    check("t1_idle_all_zero", {31'b0, |all_out}, 0);

    // 2/3: simultaneous reads from both masters, last_grant = m1 after reset
    do_reset();
    s_arready = 1'b1;
    m0_araddr = 32'h0000_0100; m1_araddr = 32'h0000_0200;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    #1;
    tick();
`ifdef MEM_ARBITER_RR_EN
    serve_read(0, 32'h0000_0100, 32'h1111_0000);
    tick();
    serve_read(1, 32'h0000_0200, 32'h2222_0000);
`else
    serve_read(1, 32'h0000_0200, 32'h2222_0000);
    tick();
    serve_read(0, 32'h0000_0100, 32'h1111_0000);
`endif

    // 4: m1 write, W two cycles ahead of AW, valids held past their ready
    aw_fires = 0; w_fires = 0; mem_word = 32'hAAAA_AAAA;
    s_awready = 1'b1; s_wready = 1'b1;
    m1_awaddr = 32'h8000_1000; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011; m1_wvalid = 1'b1;
    #1;
    check("t4_idle_s_wvalid", {31'b0, s_wvalid}, 0);
    sample_write();
    tick();
    check("t4_s_wvalid", {31'b0, s_wvalid}, 1);
    check("t4_s_wdata", s_wdata, 32'h1234_5678);
    check("t4_s_wstrb", {28'b0, s_wstrb}, 32'h3);
    check("t4_s_awvalid_early", {31'b0, s_awvalid}, 0);
    check("t4_m1_wready", {31'b0, m1_wready}, 1);
    sample_write();
    tick();
    m1_awvalid = 1'b1;
    #1;
    check("t4_s_wvalid_masked", {31'b0, s_wvalid}, 0);
    check("t4_m1_wready_masked", {31'b0, m1_wready}, 0);
    check("t4_s_awvalid", {31'b0, s_awvalid}, 1);
    check("t4_s_awaddr", s_awaddr, 32'h8000_1000);
    sample_write();
    tick();
    check("t4_s_awvalid_masked", {31'b0, s_awvalid}, 0);
    sample_write();
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_bvalid = 1'b1; m1_bready = 1'b1;
    #1;
    check("t4_m1_bvalid", {31'b0, m1_bvalid}, 1);
    check("t4_s_bready", {31'b0, s_bready}, 1);
    tick();
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    check("t4_idle_m1_bvalid", {31'b0, m1_bvalid}, 0);
    check("t4_aw_fires", aw_fires, 1);
    check("t4_w_fires", w_fires, 1);
    check("t4_sram_word", mem_word, 32'hAAAA_5678);

    // 5: SRAM stalls rvalid 5 cycles during RD_M1 while m0 waits
    m1_araddr = 32'h0000_0040; m1_arvalid = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
    #1;
    tick();
    m0_araddr = 32'h0000_0080; m0_arvalid = 1'b1;
    #1;
    check("t5_s_araddr_m1", s_araddr, 32'h0000_0040);
    check("t5_m0_arready_ar", {31'b0, m0_arready}, 0);
    tick();
    m1_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_stall_m0_arready", {31'b0, m0_arready}, 0);
      check("t5_stall_m1_rvalid", {31'b0, m1_rvalid}, 0);
      tick();
    end
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    #1;
    check("t5_m1_rvalid", {31'b0, m1_rvalid}, 1);
    check("t5_m1_rdata", m1_rdata, 32'h5555_AAAA);
    check("t5_m0_arready_r", {31'b0, m0_arready}, 0);
    tick();
    s_rvalid = 1'b0; s_rdata = 0;
    #1;
    check("t5_idle_m0_arready", {31'b0, m0_arready}, 0);
    check("t5_idle_s_arvalid", {31'b0, s_arvalid}, 0);
    tick();
    serve_read(0, 32'h0000_0080, 32'h0BAD_F00D);

    // 6: reset while in WR_M1 after aw_done
    s_awready = 1'b1; s_wready = 1'b1;
    m1_awaddr = 32'h8000_2000; m1_awvalid = 1'b1; m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF;
    #1;
    tick();
    check("t6_s_awvalid", {31'b0, s_awvalid}, 1);
    check("t6_s_wvalid_low", {31'b0, s_wvalid}, 0);
    tick();
    m1_awvalid = 1'b0;
    #1;
    check("t6_aw_done_masked", {31'b0, s_awvalid}, 0);
    rst_n = 1'b0; m1_wvalid = 1'b1; m1_bready = 1'b1; s_bvalid = 1'b1;
    s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_post_reset_all_zero", {31'b0, |all_out}, 0);
    s_bvalid = 1'b0; s_rvalid = 1'b0; s_rdata = 0; m1_awvalid = 1'b1;
    tick();
    check("t6_flags_clear_awvalid", {31'b0, s_awvalid}, 1);
    check("t6_flags_clear_wvalid", {31'b0, s_wvalid}, 1);
    tick();
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_bvalid = 1'b1;
    #1;
    check("t6_m1_bvalid", {31'b0, m1_bvalid}, 1);
    tick();
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    check("t6_end_all_zero", {31'b0, |all_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
